// File: rtl/id_ex_stage.sv
// id_ex_stage
//   ID->EX pipeline register for the 5-stage CPU. It carries the decoded
//   control bits, operands, immediate, PC and register indices from ID into
//   EX. The block also contains:
//     - the load-use and ecall-operand hazard detector,
//     - the bubble/flush insertion logic,
//     - the ecall halt sequencer. After a halting ecall is captured, the
//       sequencer lets the older instructions drain and then raises
//       is_halted.
//
// Ports
//   clk, reset                 rising-edge clock; async active-high reset
//   id_valid                   ID holds a real instruction
//   id_<ctrl>                  decoded control bits (mem_read, mem_to_reg,
//                              mem_write, alu_src, write_enable, pc_to_reg,
//                              is_ecall)
//   id_uses_rs1/2              instruction actually reads rs1/rs2
//   id_rs1/rs2/rd              register indices
//   id_rs1_data/rs2_data/imm/pc  operands, immediate, PC
//   id_alu_ctrl                ALU op select
//   id_x17_data                x17 as read in ID (ecall argument)
//   flush                      mispredict from EX; kills the ID instruction
//   ex_valid, ex_*             registered copies of the ID fields
//   hazard_stall               hold PC and IF/ID this cycle (combinational)
//   is_halted                  CPU halted; held until reset
//
// FSM states
//   state    | meaning
//   S_RUN    | normal operation; hazards may stall
//   S_DRAIN  | halting ecall is in flight; older instructions retire; front end frozen
//   S_HALTED | CPU stopped; is_halted=1 until reset
module id_ex_stage #(
  parameter int XLEN         = 32,
  parameter int HALT_CODE    = 10,
  parameter int ECALL_REG    = 17,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            id_valid,
  input  logic            id_mem_read,
  input  logic            id_mem_to_reg,
  input  logic            id_mem_write,
  input  logic            id_alu_src,
  input  logic            id_write_enable,
  input  logic            id_pc_to_reg,
  input  logic            id_is_ecall,
  input  logic            id_uses_rs1,
  input  logic            id_uses_rs2,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic [4:0]      id_rd,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [XLEN-1:0] id_pc,
  input  logic [3:0]      id_alu_ctrl,
  input  logic [XLEN-1:0] id_x17_data,
  input  logic            flush,
  output logic            ex_valid,
  output logic            ex_mem_read,
  output logic            ex_mem_to_reg,
  output logic            ex_mem_write,
  output logic            ex_alu_src,
  output logic            ex_write_enable,
  output logic            ex_pc_to_reg,
  output logic            ex_is_ecall,
  output logic [4:0]      ex_rs1,
  output logic [4:0]      ex_rs2,
  output logic [4:0]      ex_rd,
  output logic [XLEN-1:0] ex_rs1_data,
  output logic [XLEN-1:0] ex_rs2_data,
  output logic [XLEN-1:0] ex_imm,
  output logic [XLEN-1:0] ex_pc,
  output logic [3:0]      ex_alu_ctrl,
  output logic            hazard_stall,
  output logic            is_halted
);

  localparam int              CNT_W     = $clog2(DRAIN_CYCLES + 1);
  localparam logic [XLEN-1:0] HALT_VAL  = XLEN'(HALT_CODE);
  localparam logic [4:0]      ECALL_IDX = 5'(ECALL_REG);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DRAIN_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_HALTED} state_t;

  typedef struct packed {
    logic            valid;
    logic            mem_read;
    logic            mem_to_reg;
    logic            mem_write;
    logic            alu_src;
    logic            write_enable;
    logic            pc_to_reg;
    logic            is_ecall;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic [3:0]      alu_ctrl;
  } stage_t;

  state_t          state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  stage_t          id_d, ex_q;
  logic            load_use, ecall_dep, stall_raw, bubble;

  assign id_d = '{valid: id_valid, mem_read: id_mem_read, mem_to_reg: id_mem_to_reg,
                  mem_write: id_mem_write, alu_src: id_alu_src,
                  write_enable: id_write_enable, pc_to_reg: id_pc_to_reg,
                  is_ecall: id_is_ecall, rs1: id_rs1, rs2: id_rs2, rd: id_rd,
                  rs1_data: id_rs1_data, rs2_data: id_rs2_data, imm: id_imm,
                  pc: id_pc, alu_ctrl: id_alu_ctrl};

  // A load to x0 never produces a value, so it never blocks a consumer.
  assign load_use  = ex_q.valid & ex_q.mem_read & (ex_q.rd != 5'd0) &
                     ((id_uses_rs1 & (id_rs1 == ex_q.rd)) |
                      (id_uses_rs2 & (id_rs2 == ex_q.rd)));
  // ecall reads x17 in ID, so it must wait while a write to x17 is still in EX.
  assign ecall_dep = id_is_ecall & ex_q.valid & ex_q.write_enable &
                     (ex_q.rd == ECALL_IDX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    stall_raw = 1'b0;
    case (state)
      S_RUN: begin
        stall_raw = id_valid & (load_use | ecall_dep);
        if (!flush && !stall_raw && id_valid && id_is_ecall &&
            (id_x17_data == HALT_VAL)) begin
          state_nxt = S_DRAIN;
          cnt_nxt   = CNT_LOAD;
        end
      end
      S_DRAIN: begin
        stall_raw = 1'b1;
        cnt_nxt   = cnt - CNT_ONE;
        if (cnt == CNT_ONE) state_nxt = S_HALTED;
      end
      S_HALTED: stall_raw = 1'b1;
      default: state_nxt = S_RUN;
    endcase
    hazard_stall = stall_raw & ~reset;
    // Outside RUN, flush has no effect of its own; the bubble comes from the state.
    bubble = flush | stall_raw | (state != S_RUN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       ex_q <= '0;
    else if (bubble) ex_q <= '0;
    else             ex_q <= id_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) is_halted <= 1'b0;
    else       is_halted <= (state_nxt == S_HALTED);
  end

  assign ex_valid        = ex_q.valid;
  assign ex_mem_read     = ex_q.mem_read;
  assign ex_mem_to_reg   = ex_q.mem_to_reg;
  assign ex_mem_write    = ex_q.mem_write;
  assign ex_alu_src      = ex_q.alu_src;
  assign ex_write_enable = ex_q.write_enable;
  assign ex_pc_to_reg    = ex_q.pc_to_reg;
  assign ex_is_ecall     = ex_q.is_ecall;
  assign ex_rs1          = ex_q.rs1;
  assign ex_rs2          = ex_q.rs2;
  assign ex_rd           = ex_q.rd;
  assign ex_rs1_data     = ex_q.rs1_data;
  assign ex_rs2_data     = ex_q.rs2_data;
  assign ex_imm          = ex_q.imm;
  assign ex_pc           = ex_q.pc;
  assign ex_alu_ctrl     = ex_q.alu_ctrl;

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

  localparam int DRAIN = 3;

  typedef struct {
    logic        valid, mem_read, mem_to_reg, mem_write, alu_src;
    logic        write_enable, pc_to_reg, is_ecall, uses_rs1, uses_rs2;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] rs1_data, rs2_data, imm, pc, x17;
    logic [3:0]  alu_ctrl;
  } instr_t;

  typedef struct {
    int ld, we, ex_rd, v, u1, u2, rs1, rs2, ec, exp_stall;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic flush = 1'b0;
  instr_t id;

  logic        ex_valid, ex_mem_read, ex_mem_to_reg, ex_mem_write, ex_alu_src;
  logic        ex_write_enable, ex_pc_to_reg, ex_is_ecall;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [31:0] ex_rs1_data, ex_rs2_data, ex_imm, ex_pc;
  logic [3:0]  ex_alu_ctrl;
  logic        hazard_stall, is_halted;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .reset(reset),
    .id_valid(id.valid), .id_mem_read(id.mem_read), .id_mem_to_reg(id.mem_to_reg),
    .id_mem_write(id.mem_write), .id_alu_src(id.alu_src),
    .id_write_enable(id.write_enable), .id_pc_to_reg(id.pc_to_reg),
    .id_is_ecall(id.is_ecall), .id_uses_rs1(id.uses_rs1), .id_uses_rs2(id.uses_rs2),
    .id_rs1(id.rs1), .id_rs2(id.rs2), .id_rd(id.rd),
    .id_rs1_data(id.rs1_data), .id_rs2_data(id.rs2_data), .id_imm(id.imm),
    .id_pc(id.pc), .id_alu_ctrl(id.alu_ctrl), .id_x17_data(id.x17),
    .flush(flush),
    .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_mem_write(ex_mem_write), .ex_alu_src(ex_alu_src),
    .ex_write_enable(ex_write_enable), .ex_pc_to_reg(ex_pc_to_reg),
    .ex_is_ecall(ex_is_ecall), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
    .ex_pc(ex_pc), .ex_alu_ctrl(ex_alu_ctrl),
    .hazard_stall(hazard_stall), .is_halted(is_halted)
  );

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  // Reference model: EX contents as a plain record, plus a count of edges since
  // a halting ecall was accepted (-1 when none is in flight).
  instr_t m_ex;
  int     m_since_halt;
  bit     m_halted;

  function automatic instr_t blank();
    instr_t b;
    b = '{default: '0};
    return b;
  endfunction

  function automatic logic [159:0] pack_dut();
    return {5'b0, ex_valid, ex_mem_read, ex_mem_to_reg, ex_mem_write, ex_alu_src,
            ex_write_enable, ex_pc_to_reg, ex_is_ecall, ex_rs1, ex_rs2, ex_rd,
            ex_rs1_data, ex_rs2_data, ex_imm, ex_pc, ex_alu_ctrl};
  endfunction

  function automatic logic [159:0] pack_model(input instr_t e);
    return {5'b0, e.valid, e.mem_read, e.mem_to_reg, e.mem_write, e.alu_src,
            e.write_enable, e.pc_to_reg, e.is_ecall, e.rs1, e.rs2, e.rd,
            e.rs1_data, e.rs2_data, e.imm, e.pc, e.alu_ctrl};
  endfunction

  function automatic bit model_stall();
    bit lu, ed;
    if (reset) return 1'b0;
    if (m_halted || m_since_halt >= 0) return 1'b1;
    lu = m_ex.valid && m_ex.mem_read && m_ex.rd != 0 &&
         ((id.uses_rs1 && id.rs1 == m_ex.rd) || (id.uses_rs2 && id.rs2 == m_ex.rd));
    ed = id.is_ecall && m_ex.valid && m_ex.write_enable && m_ex.rd == 5'd17;
    return id.valid && (lu || ed);
  endfunction

  task automatic model_reset();
    m_ex = blank();
    m_since_halt = -1;
    m_halted = 1'b0;
  endtask

  task automatic model_edge();
    bit st;
    st = model_stall();
    if (m_halted) m_ex = blank();
    else if (m_since_halt >= 0) begin
      m_ex = blank();
      m_since_halt++;
      if (m_since_halt == DRAIN) begin
        m_halted = 1'b1;
        m_since_halt = -1;
      end
    end else if (flush || st) m_ex = blank();
    else begin
      m_ex = id;
      if (id.valid && id.is_ecall && id.x17 == 32'd10) m_since_halt = 0;
    end
  endtask

  // Advance one clock; returns at posedge+1.
  task automatic step();
    @(negedge clk);
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int v, input int mr, input int we, input int rd,
                        input int rs1, input int rs2, input int u1, input int u2,
                        input int ec, input int x17);
    id.valid        = (v != 0);
    id.mem_read     = (mr != 0);
    id.mem_to_reg   = (mr != 0);
    id.mem_write    = 1'b0;
    id.alu_src      = 1'($urandom_range(0, 1));
    id.write_enable = (we != 0);
    id.pc_to_reg    = 1'b0;
    id.is_ecall     = (ec != 0);
    id.uses_rs1     = (u1 != 0);
    id.uses_rs2     = (u2 != 0);
    id.rd           = 5'(rd);
    id.rs1          = 5'(rs1);
    id.rs2          = 5'(rs2);
    id.rs1_data     = $urandom;
    id.rs2_data     = $urandom;
    id.imm          = $urandom;
    id.pc           = $urandom;
    id.alu_ctrl     = 4'($urandom_range(0, 15));
    id.x17          = 32'(x17);
  endtask

  task automatic rand_op();
    id.valid        = ($urandom_range(0, 9) != 0);
    id.mem_read     = 1'($urandom_range(0, 1));
    id.mem_to_reg   = 1'($urandom_range(0, 1));
    id.mem_write    = 1'($urandom_range(0, 1));
    id.alu_src      = 1'($urandom_range(0, 1));
    id.write_enable = 1'($urandom_range(0, 1));
    id.pc_to_reg    = 1'($urandom_range(0, 1));
    id.is_ecall     = ($urandom_range(0, 19) == 0);
    id.uses_rs1     = 1'($urandom_range(0, 1));
    id.uses_rs2     = 1'($urandom_range(0, 1));
    id.rs1          = ($urandom_range(0, 7) == 0) ? 5'd17 : 5'($urandom_range(0, 7));
    id.rs2          = 5'($urandom_range(0, 7));
    id.rd           = ($urandom_range(0, 5) == 0) ? 5'd17 : 5'($urandom_range(0, 7));
    id.rs1_data     = $urandom;
    id.rs2_data     = $urandom;
    id.imm          = $urandom;
    id.pc           = $urandom;
    id.alu_ctrl     = 4'($urandom_range(0, 15));
    id.x17          = ($urandom_range(0, 2) == 0) ? 32'd10 : $urandom;
    flush           = ($urandom_range(0, 9) == 0);
  endtask

  vec_t vt[12];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not reach the summary in time");
    $fatal(1);
  end

  initial begin
    //        ld we ex_rd  v u1 u2 rs1 rs2 ec  stall
    vt[0]  = '{1, 1, 5,    1, 1, 0, 5,  0,  0, 1};
    vt[1]  = '{1, 1, 5,    1, 0, 1, 0,  5,  0, 1};
    vt[2]  = '{1, 1, 0,    1, 1, 1, 0,  0,  0, 0};
    vt[3]  = '{1, 1, 5,    1, 1, 0, 1,  5,  0, 0};
    vt[4]  = '{0, 1, 5,    1, 1, 1, 5,  5,  0, 0};
    vt[5]  = '{1, 1, 5,    0, 1, 1, 5,  5,  0, 0};
    vt[6]  = '{0, 1, 17,   1, 0, 0, 0,  0,  1, 1};
    vt[7]  = '{0, 0, 17,   1, 0, 0, 0,  0,  1, 0};
    vt[8]  = '{0, 1, 16,   1, 0, 0, 0,  0,  1, 0};
    vt[9]  = '{1, 1, 17,   1, 0, 0, 0,  0,  1, 1};
    vt[10] = '{1, 1, 31,   1, 0, 1, 3,  31, 0, 1};
    vt[11] = '{1, 0, 5,    1, 1, 0, 5,  0,  0, 1};

    id = blank();
    model_reset();
    #2;
    check("rst_ex", pack_dut(), 160'd0);
    check1("rst_halt", is_halted, 1'b0);
    check1("rst_stall", hazard_stall, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // lw x5 then dependent add: one stall, one bubble, then the add
    set_op(1, 1, 1, 5, 0, 0, 0, 0, 0, 0);
    step();
    check("s1_lw", 160'({ex_valid, ex_mem_read, ex_rd}), 160'({1'b1, 1'b1, 5'd5}));
    set_op(1, 0, 1, 6, 5, 1, 1, 1, 0, 0);
    #1 check1("s1_stall", hazard_stall, 1'b1);
    step();
    check1("s1_bubble", ex_valid, 1'b0);
    check1("s1_stall_gone", hazard_stall, 1'b0);
    step();
    check("s1_add", 160'({ex_valid, ex_rd, ex_rs1}), 160'({1'b1, 5'd6, 5'd5}));

    // table: EX preloaded by one capture, then ID pattern checked for stall
    for (int k = 0; k < 12; k++) begin
      set_op(1, vt[k].ld, vt[k].we, vt[k].ex_rd, 0, 0, 0, 0, 0, 0);
      step();
      set_op(vt[k].v, 0, 0, 9, vt[k].rs1, vt[k].rs2, vt[k].u1, vt[k].u2, vt[k].ec, 5);
      #1 check1($sformatf("vec%0d_stall", k), hazard_stall, vt[k].exp_stall != 0);
    end

    // flush kills a valid add; flush plus load-use gives a single bubble
    set_op(1, 0, 1, 7, 1, 2, 1, 1, 0, 0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("s3_flush", 160'({ex_valid, ex_write_enable}), 160'd0);
    set_op(1, 1, 1, 5, 0, 0, 0, 0, 0, 0);
    step();
    set_op(1, 0, 1, 8, 5, 0, 1, 0, 0, 0);
    flush = 1'b1;
    #1 check1("s3_stall", hazard_stall, 1'b1);
    step();
    flush = 1'b0;
    check1("s3_bubble", ex_valid, 1'b0);
    set_op(1, 0, 1, 9, 3, 4, 1, 1, 0, 0);
    step();
    check("s3_one_bubble", 160'({ex_valid, ex_rd}), 160'({1'b1, 5'd9}));

    // ecall with x17=9 is an ordinary instruction
    set_op(1, 0, 0, 0, 0, 0, 0, 0, 1, 9);
    #1 check1("s5_stall", hazard_stall, 1'b0);
    step();
    check("s5_ecall_ex", 160'({ex_valid, ex_is_ecall}), 160'(2'b11));
    set_op(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(); step(); step();
    check1("s5_no_halt", is_halted, 1'b0);
    check1("s5_no_stall", hazard_stall, 1'b0);

    // addi x17 in EX, halting ecall in ID: stall, bubble, drain, halt
    set_op(1, 0, 1, 17, 0, 0, 1, 0, 0, 0);
    step();
    set_op(1, 0, 0, 0, 0, 0, 0, 0, 1, 10);
    #1 check1("s4_ecall_stall", hazard_stall, 1'b1);
    step();
    check1("s4_bubble0", ex_valid, 1'b0);
    check1("s4_stall_gone", hazard_stall, 1'b0);
    step();
    check("s4_ecall_ex", 160'({ex_valid, ex_is_ecall}), 160'(2'b11));
    check1("s4_not_yet", is_halted, 1'b0);
    check1("s4_drain_stall", hazard_stall, 1'b1);
    set_op(1, 0, 1, 3, 0, 0, 0, 0, 0, 0);
    flush = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step();
      check1($sformatf("s4_drain_bubble%0d", i), ex_valid, 1'b0);
      check1($sformatf("s4_halt%0d", i), is_halted, i == 3);
      check1($sformatf("s4_stall%0d", i), hazard_stall, 1'b1);
    end
    flush = 1'b0;
    step();
    check1("s4_halt_sticky", is_halted, 1'b1);

    // async reset in the middle of a drain
    reset = 1'b1;
    model_reset();
    #1 reset = 1'b0;
    set_op(1, 0, 0, 0, 0, 0, 0, 0, 1, 10);
    step();
    set_op(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    check1("s6_in_drain", hazard_stall, 1'b1);
    reset = 1'b1;
    #1;
    check("s6_rst_ex", pack_dut(), 160'd0);
    check1("s6_rst_halt", is_halted, 1'b0);
    check1("s6_rst_stall", hazard_stall, 1'b0);
    model_reset();
    #1 reset = 1'b0;
    set_op(1, 0, 1, 4, 1, 2, 1, 1, 0, 0);
    step();
    check("s6_resume", 160'({ex_valid, ex_rd}), 160'({1'b1, 5'd4}));
    step(); step(); step();
    check1("s6_run_halt", is_halted, 1'b0);
    check1("s6_run_stall", hazard_stall, 1'b0);

    // randomized traffic against the model, with occasional async resets
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 49) == 0 || (m_halted && $urandom_range(0, 3) == 0)) begin
        reset = 1'b1;
        #1;
        check("rnd_rst_ex", pack_dut(), 160'd0);
        check1("rnd_rst_stall", hazard_stall, 1'b0);
        model_reset();
        #1 reset = 1'b0;
      end
      rand_op();
      #1 check1("rnd_stall", hazard_stall, model_stall());
      step();
      check("rnd_ex", pack_dut(), pack_model(m_ex));
      check1("rnd_halt", is_halted, m_halted);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
